// File: rtl/odd_even_sort_sched.sv
// Odd-even transposition sorter: one shared registered compare-exchange unit
// is scheduled over an N-entry register file, one pair per cycle.
module odd_even_sort_sched #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*W-1:0]          in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*W-1:0]          out_data,
  output logic                    busy,
  output logic [$clog2(N*N):0]    swap_count
);

  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned SCW  = $clog2(N*N) + 1;
  localparam int unsigned HALF = N / 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     phase_q, phase_d;
  logic [IW-1:0]     pair_q, pair_d;
  logic [W-1:0]      rf_q [N];
  logic [W-1:0]      rf_d [N];
  logic [N*W-1:0]    out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic [SCW-1:0]    swap_q, swap_d;

  logic [IW-1:0]     lo_idx, hi_idx, next_phase;
  logic [W-1:0]      lo_w, hi_w;
  logic              swap_c, last_pair_c;

  // Even phases start at slot 0, odd phases at slot 1.
  function automatic int unsigned pairs_in(input logic [IW-1:0] p);
    return p[0] ? HALF - 1 : HALF;
  endfunction

  assign lo_idx      = IW'({pair_q, 1'b0}) + IW'(phase_q[0]);
  assign hi_idx      = lo_idx + IW'(1);
  assign lo_w        = rf_q[lo_idx];
  assign hi_w        = rf_q[hi_idx];
  assign swap_c      = lo_w > hi_w;
  assign last_pair_c = (32'(pair_q) + 32'd1) == pairs_in(phase_q);
  assign next_phase  = phase_q + IW'(1);

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pair_d      = pair_q;
    rf_d        = rf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    swap_d      = swap_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          for (int i = 0; i < int'(N); i++) rf_d[i] = in_data[i*W +: W];
          swap_d  = '0;
          phase_d = '0;
          pair_d  = '0;
          state_d = (pairs_in('0) == 0) ? S_WAIT : S_RUN;
        end
      end
      S_RUN: begin
        // Unit result lands in the register file on this edge.
        if (swap_c) begin
          rf_d[lo_idx] = hi_w;
          rf_d[hi_idx] = lo_w;
          if (swap_q != {SCW{1'b1}}) swap_d = swap_q + SCW'(1);
        end
        if (last_pair_c) begin
          pair_d  = '0;
          state_d = S_WAIT;
        end else begin
          pair_d  = pair_q + IW'(1);
        end
      end
      S_WAIT: begin
        if (32'(phase_q) != N - 1) begin
          phase_d = next_phase;
          pair_d  = '0;
          state_d = (pairs_in(next_phase) == 0) ? S_WAIT : S_RUN;
        end else begin
          for (int i = 0; i < int'(N); i++) out_data_d[i*W +: W] = rf_q[i];
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d == S_RUN) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      pair_q      <= '0;
      for (int i = 0; i < int'(N); i++) rf_q[i] <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      swap_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pair_q      <= pair_d;
      rf_q        <= rf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      swap_q      <= swap_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign swap_count = swap_q;

endmodule
